ieeedrv_host_src: RTL and testbench



---
 rtl/ieeedrv_host_src_if.sv | 38 +++
 rtl/ieeedrv_host_src.sv | 193 +++++++++++++++++++
 tb/tb_ieeedrv_host_src.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ieeedrv_host_src_if.sv
// Shared IEEE-488 bus record and the host-side byte channel of the
// source-handshake engine.
package ieeedrv_pkg;
   typedef struct packed {
      logic [7:0] data;
      logic       atn;
      logic       eoi;
      logic       dav;
      logic       nrfd;
      logic       ndac;
      logic       ifc;
      logic       srq;
      logic       ren;
   } st_ieee_bus;
endpackage

interface ieeedrv_host_src_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_atn;
   logic       tx_eoi;
   logic       ifc_req;
   logic       busy;
   logic       done;
   logic       err_nodev;
   logic       err_timeout;

   modport master (
      output tx_valid, tx_data, tx_atn, tx_eoi, ifc_req,
      input  tx_ready, busy, done, err_nodev, err_timeout
   );

   modport slave (
      input  tx_valid, tx_data, tx_atn, tx_eoi, ifc_req,
      output tx_ready, busy, done, err_nodev, err_timeout
   );
endinterface

// File: rtl/ieeedrv_host_src.sv
// Host-side IEEE-488 source handshake: places command/data bytes on the bus
// with the DAV/NRFD/NDAC protocol and issues IFC pulses on request.
module ieeedrv_host_src
   import ieeedrv_pkg::*;
#(
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 16'hFFFF,
   parameter int unsigned IFC_LEN = 100
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ce,
   input  st_ieee_bus        bus_i,
   output st_ieee_bus        bus_o,
   ieeedrv_host_src_if.slave tx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_WAIT_RFD,
      S_DAV_ON,
      S_DAV_OFF,
      S_IFC
   } state_t;

   localparam logic [15:0] SETTLE_T  = 16'(SETTLE);
   localparam logic [15:0] TIMEOUT_T = 16'(TIMEOUT);
   localparam logic [15:0] IFC_T     = 16'(IFC_LEN);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_inc;
   logic [7:0]  data_q;
   logic        atn_q;
   logic        eoi_q;
   logic        dav_q;
   logic        ifc_q;
   logic        nodev_q;
   logic        tout_q;
   logic        settled;
   logic        expired;
   logic        ifc_over;
   logic        no_listener;
   logic        ready_c;
   logic        busy_c;
   logic        done_c;
   logic        bus_unused;

   assign bus_unused = &{1'b0, bus_i.data, bus_i.atn, bus_i.eoi, bus_i.dav,
                         bus_i.ifc, bus_i.srq, bus_i.ren};

   // Settling is judged on ticks already elapsed; the wait limits on the
   // tick being taken now, so a limit of N means exactly N ticks in state.
   assign cnt_inc     = (ce && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
   assign settled     = cnt >= SETTLE_T;
   assign expired     = cnt_inc >= TIMEOUT_T;
   assign ifc_over    = cnt_inc >= IFC_T;
   assign no_listener = !bus_i.nrfd && !bus_i.ndac;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (tx.ifc_req) begin
               state_nxt = S_IFC;
            end else if (tx.tx_valid) begin
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settled) begin
               state_nxt = no_listener ? S_IDLE : S_WAIT_RFD;
            end
         end
         S_WAIT_RFD: begin
            if (!bus_i.nrfd) begin
               state_nxt = S_DAV_ON;
            end else if (expired) begin
               state_nxt = S_IDLE;
            end
         end
         S_DAV_ON: begin
            if (!bus_i.ndac) begin
               state_nxt = S_DAV_OFF;
            end else if (expired) begin
               state_nxt = S_IDLE;
            end
         end
         S_DAV_OFF: state_nxt = S_IDLE;
         S_IFC: begin
            if (ifc_over) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ATN is only touched at accept, IFC entry and reset; aborts leave it.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= 16'd0;
         data_q  <= 8'd0;
         atn_q   <= 1'b0;
         eoi_q   <= 1'b0;
         dav_q   <= 1'b0;
         ifc_q   <= 1'b0;
         nodev_q <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         cnt     <= cnt_inc;
         nodev_q <= 1'b0;
         tout_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tx.ifc_req) begin
                  ifc_q <= 1'b1;
                  atn_q <= 1'b0;
                  cnt   <= 16'd0;
               end else if (tx.tx_valid) begin
                  data_q <= tx.tx_data;
                  eoi_q  <= tx.tx_eoi;
                  atn_q  <= tx.tx_atn;
                  cnt    <= 16'd0;
               end
            end
            S_SETTLE: begin
               if (settled) begin
                  cnt <= 16'd0;
                  if (no_listener) begin
                     nodev_q <= 1'b1;
                     data_q  <= 8'd0;
                     eoi_q   <= 1'b0;
                  end
               end
            end
            S_WAIT_RFD: begin
               if (!bus_i.nrfd) begin
                  dav_q <= 1'b1;
                  cnt   <= 16'd0;
               end else if (expired) begin
                  tout_q <= 1'b1;
                  data_q <= 8'd0;
                  eoi_q  <= 1'b0;
               end
            end
            S_DAV_ON: begin
               if (!bus_i.ndac || expired) begin
                  dav_q  <= 1'b0;
                  data_q <= 8'd0;
                  eoi_q  <= 1'b0;
                  tout_q <= bus_i.ndac;
               end
            end
            S_IFC: begin
               if (ifc_over) begin
                  ifc_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus_o      = '0;
      bus_o.data = data_q;
      bus_o.atn  = atn_q;
      bus_o.eoi  = eoi_q;
      bus_o.dav  = dav_q;
      bus_o.ifc  = ifc_q;
      ready_c    = (state == S_IDLE) && !tx.ifc_req;
      busy_c     = state != S_IDLE;
      done_c     = state == S_DAV_OFF;
   end

   assign tx.tx_ready    = ready_c;
   assign tx.busy        = busy_c;
   assign tx.done        = done_c;
   assign tx.err_nodev   = nodev_q;
   assign tx.err_timeout = tout_q;

endmodule

// File: tb/tb_ieeedrv_host_src.sv
// Self-checking bench: randomized bytes against a listener model, with
// expected timing and outcomes computed arithmetically from the handshake rules.
module tb_ieeedrv_host_src;
   import ieeedrv_pkg::*;

   localparam int SETTLE  = 2;
   localparam int TIMEOUT = 16;
   localparam int IFC_LEN = 100;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce      = 1'b1;
   logic       lst_nrfd = 1'b0;
   logic       lst_ndac = 1'b0;
   logic       exp_atn  = 1'b0;
   st_ieee_bus bus_i;
   st_ieee_bus bus_o;
   int         tests = 0;
   int         fails = 0;

   ieeedrv_host_src_if tx();

   ieeedrv_host_src #(
      .SETTLE (SETTLE),
      .TIMEOUT(TIMEOUT),
      .IFC_LEN(IFC_LEN)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .ce     (ce),
      .bus_i  (bus_i),
      .bus_o  (bus_o),
      .tx     (tx)
   );

   always #5 clk_sys = ~clk_sys;

   always_comb begin
      bus_i      = bus_o;
      bus_i.nrfd = bus_o.nrfd | lst_nrfd;
      bus_i.ndac = bus_o.ndac | lst_ndac;
   end

   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // r: first cycle after accept with NRFD released (999 = never);
   // a: cycles after DAV seen before NDAC is released (999 = never).
   task automatic apply_stimulus(input logic [7:0] d, input logic a_tn, input logic e_oi,
                                 input bit present, input int r, input int a,
                                 input bit ifc_at_rise);
      int kind, w, dd, exp_rise, exp_fall, exp_idle, exp_out;
      int rise_t, fall_t, out_t, idle_t, done_n, nodev_n, to_n, stable_bad;
      logic [7:0] d_rise;
      logic e_rise, a_rise;
      if (!present) begin
         kind = 1; exp_rise = 0; exp_fall = 0; exp_idle = SETTLE + 2;
      end else begin
         w = (r > SETTLE + 2) ? r : SETTLE + 2;
         if (w >= SETTLE + 2 + TIMEOUT) begin
            kind = 2; exp_rise = 0; exp_fall = 0; exp_idle = SETTLE + 2 + TIMEOUT;
         end else begin
            dd = w + 1;
            exp_rise = dd;
            if (a < TIMEOUT) begin
               kind = 0; exp_fall = dd + a + 1; exp_idle = dd + a + 2;
            end else begin
               kind = 2; exp_fall = dd + TIMEOUT; exp_idle = dd + TIMEOUT;
            end
         end
      end
      exp_out = (kind == 0) ? exp_idle - 1 : exp_idle;

      check_output("ready_at_offer", 32'(tx.tx_ready), 32'h1);
      tx.tx_valid = 1'b1;
      tx.tx_data  = d;
      tx.tx_atn   = a_tn;
      tx.tx_eoi   = e_oi;
      exp_atn     = a_tn;
      lst_nrfd    = present && (r > 0);
      lst_ndac    = present;
      rise_t = 0; fall_t = 0; out_t = 0; idle_t = 0;
      done_n = 0; nodev_n = 0; to_n = 0; stable_bad = 0;
      d_rise = 8'h0; e_rise = 1'b0; a_rise = 1'b0;
      for (int t = 1; t <= 48; t++) begin
         @(negedge clk_sys);
         tx.tx_valid = 1'b0;
         if (t == 1) begin
            check_output("accept_data", 32'(bus_o.data), 32'(d));
            check_output("accept_eoi", 32'(bus_o.eoi), 32'(e_oi));
            check_output("accept_atn", 32'(bus_o.atn), 32'(a_tn));
            check_output("accept_busy", 32'(tx.busy), 32'h1);
         end
         if (bus_o.dav && rise_t == 0) begin
            rise_t = t; d_rise = bus_o.data; e_rise = bus_o.eoi; a_rise = bus_o.atn;
            if (ifc_at_rise) tx.ifc_req = 1'b1;
         end
         if (bus_o.dav && (bus_o.data != d || bus_o.eoi != e_oi)) stable_bad++;
         if (!bus_o.dav && rise_t != 0 && fall_t == 0) fall_t = t;
         if (tx.done || tx.err_nodev || tx.err_timeout) out_t = t;
         done_n  += int'(tx.done);
         nodev_n += int'(tx.err_nodev);
         to_n    += int'(tx.err_timeout);
         if (!tx.busy) begin
            idle_t = t;
            break;
         end
         lst_nrfd = present && (t < r);
         lst_ndac = present && !(rise_t != 0 && t >= rise_t + a);
      end
      check_output("dav_rise_cycle", 32'(rise_t), 32'(exp_rise));
      check_output("dav_fall_cycle", 32'(fall_t), 32'(exp_fall));
      check_output("pulse_cycle", 32'(out_t), 32'(exp_out));
      check_output("idle_cycle", 32'(idle_t), 32'(exp_idle));
      check_output("done_count", 32'(done_n), 32'(kind == 0));
      check_output("nodev_count", 32'(nodev_n), 32'(kind == 1));
      check_output("timeout_count", 32'(to_n), 32'(kind == 2));
      check_output("data_stable_with_dav", 32'(stable_bad), 32'h0);
      if (exp_rise != 0) begin
         check_output("data_at_dav", 32'(d_rise), 32'(d));
         check_output("eoi_at_dav", 32'(e_rise), 32'(e_oi));
         check_output("atn_at_dav", 32'(a_rise), 32'(a_tn));
      end
      check_output("end_dav", 32'(bus_o.dav), 32'h0);
      check_output("end_data", 32'(bus_o.data), 32'h0);
      check_output("end_eoi", 32'(bus_o.eoi), 32'h0);
      check_output("end_atn", 32'(bus_o.atn), 32'(exp_atn));
      check_output("end_ready", 32'(tx.tx_ready), 32'(!ifc_at_rise));
   endtask

   // Holds ifc_req until IFC is seen, then counts ce ticks spent with IFC asserted.
   task automatic run_ifc(input bit random_ce);
      int high_n, ticks, atn_bad, ready_bad;
      bit seen;
      high_n = 0; ticks = 0; atn_bad = 0; ready_bad = 0; seen = 0;
      tx.ifc_req = 1'b1;
      for (int t = 0; t < 600; t++) begin
         if (t > 0) @(negedge clk_sys);
         if ((tx.ifc_req || bus_o.ifc) && tx.tx_ready) ready_bad++;
         if (bus_o.ifc) begin
            seen = 1;
            high_n++;
            if (bus_o.atn) atn_bad++;
            tx.ifc_req = 1'b0;
         end else if (seen) begin
            break;
         end
         ce = random_ce ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus_o.ifc) ticks += int'(ce);
      end
      ce = 1'b1;
      tx.ifc_req = 1'b0;
      exp_atn = 1'b0;
      check_output("ifc_seen", 32'(seen), 32'h1);
      check_output("ifc_ticks", 32'(ticks), 32'(IFC_LEN));
      if (!random_ce) check_output("ifc_cycles", 32'(high_n), 32'(IFC_LEN));
      check_output("ifc_atn_low", 32'(atn_bad), 32'h0);
      check_output("ifc_ready_low", 32'(ready_bad), 32'h0);
      check_output("ifc_end_busy", 32'(tx.busy), 32'h0);
      check_output("ifc_end_atn", 32'(bus_o.atn), 32'h0);
   endtask

   initial begin
      int dav_wait;
      tx.tx_valid = 1'b0;
      tx.tx_data  = 8'h0;
      tx.tx_atn   = 1'b0;
      tx.tx_eoi   = 1'b0;
      tx.ifc_req  = 1'b1;
      repeat (3) @(negedge clk_sys);
      check_output("rst_ready_ifc", 32'(tx.tx_ready), 32'h0);
      tx.ifc_req = 1'b0;
      #1;
      check_output("rst_bus", 32'(bus_o), 32'h0);
      check_output("rst_ready", 32'(tx.tx_ready), 32'h1);
      check_output("rst_busy", 32'(tx.busy), 32'h0);
      check_output("rst_pulses", 32'({tx.done, tx.err_nodev, tx.err_timeout}), 32'h0);
      @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);

      apply_stimulus(8'h41, 1'b0, 1'b0, 1, 2, 3, 0);
      apply_stimulus(8'h28, 1'b1, 1'b0, 1, 1, 1, 0);
      apply_stimulus(8'h6F, 1'b1, 1'b0, 1, 0, 2, 0);
      apply_stimulus(8'h24, 1'b0, 1'b1, 1, 3, 0, 0);
      apply_stimulus(8'h55, 1'b0, 1'b0, 0, 0, 0, 0);
      apply_stimulus(8'h33, 1'b1, 1'b0, 1, 999, 0, 0);
      apply_stimulus(8'h66, 1'b1, 1'b1, 1, 0, 999, 0);
      apply_stimulus(8'h77, 1'b1, 1'b0, 1, 2, 3, 1);
      run_ifc(0);

      for (int i = 0; i < 30; i++) begin
         apply_stimulus(8'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 9) != 0,
                        ($urandom_range(0, 7) == 0) ? 999 : int'($urandom_range(0, 10)),
                        ($urandom_range(0, 7) == 0) ? 999 : int'($urandom_range(0, 6)),
                        $urandom_range(0, 9) == 0);
         if (!tx.tx_ready) run_ifc(1);
      end

      // Reset while DAV is asserted must clear the bus without a clock edge.
      tx.tx_valid = 1'b1;
      tx.tx_data  = 8'hA5;
      tx.tx_atn   = 1'b1;
      tx.tx_eoi   = 1'b1;
      lst_nrfd = 1'b0;
      lst_ndac = 1'b1;
      dav_wait = 0;
      @(negedge clk_sys);
      tx.tx_valid = 1'b0;
      while (!bus_o.dav && dav_wait < 20) begin
         @(negedge clk_sys);
         dav_wait++;
      end
      check_output("rst_mid_dav_seen", 32'(bus_o.dav), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check_output("rst_mid_bus", 32'(bus_o), 32'h0);
      check_output("rst_mid_pulses", 32'({tx.done, tx.err_nodev, tx.err_timeout}), 32'h0);
      @(negedge clk_sys);
      check_output("rst_mid_held", 32'({bus_o, tx.done, tx.err_nodev, tx.err_timeout}), 32'h0);
      reset_n = 1'b1;
      @(negedge clk_sys);
      check_output("rst_mid_ready", 32'(tx.tx_ready), 32'h1);
      check_output("rst_mid_busy", 32'(tx.busy), 32'h0);
      check_output("rst_mid_after_pulses", 32'({tx.done, tx.err_nodev, tx.err_timeout}), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
